// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state encoding, opcode/funct constants and mux codes for multicycle_controller
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_JR        = 4'd10,
        S_I_EXEC    = 4'd11,
        S_I_WB      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_SLTU  = 3'b101;
    localparam logic [2:0] ALU_OR    = 3'b110;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

    function automatic logic is_shift_imm(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// rtl/mc_mem_timer.sv - consecutive memory wait-cycle counter with timeout compare
module mc_mem_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic in_wait,
    input  logic mem_ready,
    output logic timeout
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [TW-1:0] count;

    // Counter holds 0 outside wait states, so every wait-state entry starts from 0.
    assign timeout = (MEM_TIMEOUT > 0) && in_wait && !mem_ready
                     && (count == TW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || !in_wait || mem_ready || timeout) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for a multi-cycle MIPS datapath
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ExtOp,
    output logic             LuOp,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal_insn,
    output logic             mem_fault,
    output logic [CNT_W-1:0] instr_count
);

    state_t cur, nxt;
    logic   timeout, retire;
    logic   pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal;

    mc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .in_wait   (is_wait_state(cur)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    // A timed-out store never reaches here with mem_ready=1, so it is not counted.
    assign retire = (cur inside {S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_JR, S_I_WB})
                    || (cur == S_MEM_WRITE && mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= S_FETCH;
            instr_count <= '0;
            mem_fault   <= 1'b0;
        end else begin
            cur <= nxt;
            if (retire)  instr_count <= instr_count + CNT_W'(1);
            if (timeout) mem_fault   <= 1'b1;
        end
    end

    always_comb begin
        nxt           = cur;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        IorD          = 1'b0;
        RegDst        = REGDST_RT;
        MemtoReg      = M2R_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_REG;
        ExtOp         = 1'b0;
        LuOp          = 1'b0;
        ALUOp         = ALU_ADD;
        PCSource      = PCSRC_ALU;
        case (cur)
            S_FETCH: begin
                mem_read = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                ir_write = mem_ready;
                pc_write = mem_ready;
                if (mem_ready) nxt = S_DECODE;
                else if (timeout) nxt = S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BRANCH;
                ExtOp   = 1'b1;
                case (OpCode)
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_RTYPE:     nxt = (Funct == FN_JR || Funct == FN_JALR) ? S_JR : S_R_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J, OP_JAL: nxt = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_LUI: nxt = S_I_EXEC;
                    default: begin
                        illegal = 1'b1;
                        nxt     = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                ExtOp   = 1'b1;
                nxt     = (OpCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                IorD     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) nxt = S_MEM_WB;
                else if (timeout) nxt = S_FETCH;
            end
            S_MEM_WB: begin
                MemtoReg  = M2R_MDR;
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_MEM_WRITE: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready || timeout) nxt = S_FETCH;
            end
            S_R_EXEC: begin
                ALUSrcA = is_shift_imm(Funct) ? SRCA_SHAMT : SRCA_REG;
                ALUOp   = ALU_FUNCT;
                nxt     = S_R_WB;
            end
            S_R_WB: begin
                RegDst    = REGDST_RD;
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA       = SRCA_REG;
                ALUOp         = ALU_SUB;
                pc_write_cond = 1'b1;
                PCSource      = PCSRC_ALUOUT;
                nxt           = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                PCSource = PCSRC_JUMP;
                if (OpCode == OP_JAL) begin
                    reg_write = 1'b1;
                    RegDst    = REGDST_RA;
                    MemtoReg  = M2R_PC;
                end
                nxt = S_FETCH;
            end
            S_JR: begin
                pc_write = 1'b1;
                PCSource = PCSRC_REG;
                if (Funct == FN_JALR) begin
                    reg_write = 1'b1;
                    RegDst    = REGDST_RD;
                    MemtoReg  = M2R_PC;
                end
                nxt = S_FETCH;
            end
            S_I_EXEC: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                ExtOp   = !(OpCode inside {OP_ANDI, OP_ORI, OP_SLTIU});
                LuOp    = (OpCode == OP_LUI);
                case (OpCode)
                    OP_ANDI:  ALUOp = ALU_AND;
                    OP_ORI:   ALUOp = ALU_OR;
                    OP_SLTI:  ALUOp = ALU_SLT;
                    OP_SLTIU: ALUOp = ALU_SLTU;
                    default:  ALUOp = ALU_ADD;
                endcase
                nxt = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // Strobes are suppressed for the whole reset cycle.
    assign PCWrite      = pc_write      && !reset;
    assign PCWriteCond  = pc_write_cond && !reset;
    assign MemRead      = mem_read      && !reset;
    assign MemWrite     = mem_write     && !reset;
    assign IRWrite      = ir_write      && !reset;
    assign RegWrite     = reg_write     && !reset;
    assign illegal_insn = illegal       && !reset;
    assign state        = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, rw;
        logic [1:0] regdst, m2r, srca, srcb;
        logic       extop, luop;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       ill, fault;
        logic [3:0] st;
        logic [7:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset, mem_ready;
    logic [5:0] OpCode, Funct;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic       ExtOp, LuOp, illegal_insn, mem_fault;
    logic [2:0] ALUOp;
    logic [3:0] state;
    logic [7:0] instr_count;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic [7:0] exp_cnt;
    logic       exp_fault;

    multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
        .LuOp(LuOp), .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
        .illegal_insn(illegal_insn), .mem_fault(mem_fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic obs_t f_fetch(input logic rdy);
        obs_t e = '0;
        e.st = 4'd0; e.mrd = 1'b1; e.srcb = 2'b01; e.pcw = rdy; e.irw = rdy;
        return e;
    endfunction
    function automatic obs_t f_decode(input logic ill);
        obs_t e = '0;
        e.st = 4'd1; e.srcb = 2'b11; e.extop = 1'b1; e.ill = ill;
        return e;
    endfunction
    function automatic obs_t f_memaddr();
        obs_t e = '0;
        e.st = 4'd2; e.srca = 2'b01; e.srcb = 2'b10; e.extop = 1'b1;
        return e;
    endfunction
    function automatic obs_t f_memread();
        obs_t e = '0;
        e.st = 4'd3; e.iord = 1'b1; e.mrd = 1'b1;
        return e;
    endfunction
    function automatic obs_t f_memwb();
        obs_t e = '0;
        e.st = 4'd4; e.rw = 1'b1; e.m2r = 2'b01;
        return e;
    endfunction
    function automatic obs_t f_memwrite();
        obs_t e = '0;
        e.st = 4'd5; e.iord = 1'b1; e.mwr = 1'b1;
        return e;
    endfunction
    function automatic obs_t f_rexec(input logic [1:0] srca);
        obs_t e = '0;
        e.st = 4'd6; e.srca = srca; e.aluop = 3'b010;
        return e;
    endfunction
    function automatic obs_t f_rwb();
        obs_t e = '0;
        e.st = 4'd7; e.rw = 1'b1; e.regdst = 2'b01;
        return e;
    endfunction
    function automatic obs_t f_branch();
        obs_t e = '0;
        e.st = 4'd8; e.srca = 2'b01; e.aluop = 3'b001; e.pcwc = 1'b1; e.pcsrc = 2'b01;
        return e;
    endfunction
    function automatic obs_t f_jal();
        obs_t e = '0;
        e.st = 4'd9; e.pcw = 1'b1; e.pcsrc = 2'b10; e.rw = 1'b1; e.regdst = 2'b10; e.m2r = 2'b10;
        return e;
    endfunction
    function automatic obs_t f_iexec(input logic ext, input logic [2:0] op);
        obs_t e = '0;
        e.st = 4'd11; e.srca = 2'b01; e.srcb = 2'b10; e.extop = ext; e.aluop = op;
        return e;
    endfunction
    function automatic obs_t f_iwb();
        obs_t e = '0;
        e.st = 4'd12; e.rw = 1'b1;
        return e;
    endfunction

    // One clock of stimulus; the expectation covers the outputs seen during that clock.
    task automatic cyc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic rst, input obs_t e);
        @(posedge clk);
        #1;
        OpCode = op; Funct = fn; mem_ready = rdy; reset = rst;
        e.cnt   = exp_cnt;
        e.fault = exp_fault;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  act, e;
            string t;
            act = '0;
            act.pcw = PCWrite; act.pcwc = PCWriteCond; act.iord = IorD; act.mrd = MemRead;
            act.mwr = MemWrite; act.irw = IRWrite; act.rw = RegWrite; act.regdst = RegDst;
            act.m2r = MemtoReg; act.srca = ALUSrcA; act.srcb = ALUSrcB; act.extop = ExtOp;
            act.luop = LuOp; act.aluop = ALUOp; act.pcsrc = PCSource; act.ill = illegal_insn;
            act.fault = mem_fault; act.st = state; act.cnt = instr_count;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s actual=%h required=%h", t, act, e);
            end
        end
    end

    initial begin
        obs_t e;
        reset = 1'b1; mem_ready = 1'b0; OpCode = 6'h00; Funct = 6'h00;
        exp_cnt = 8'd0; exp_fault = 1'b0;

        e = f_fetch(1'b1); e.pcw = 1'b0; e.irw = 1'b0; e.mrd = 1'b0;
        cyc("reset_fetch", 6'h08, 6'h00, 1'b1, 1'b1, e);

        cyc("addi_fetch",  6'h08, 6'h00, 1'b1, 1'b0, f_fetch(1'b1));
        cyc("addi_decode", 6'h08, 6'h00, 1'b1, 1'b0, f_decode(1'b0));
        cyc("addi_iexec",  6'h08, 6'h00, 1'b1, 1'b0, f_iexec(1'b1, 3'b000));
        cyc("addi_iwb",    6'h08, 6'h00, 1'b1, 1'b0, f_iwb());
        exp_cnt = 8'd1;

        cyc("lw_fetch",   6'h23, 6'h00, 1'b1, 1'b0, f_fetch(1'b1));
        cyc("lw_decode",  6'h23, 6'h00, 1'b1, 1'b0, f_decode(1'b0));
        cyc("lw_memaddr", 6'h23, 6'h00, 1'b1, 1'b0, f_memaddr());
        for (int i = 0; i < 3; i++)
            cyc("lw_memread_wait", 6'h23, 6'h00, 1'b0, 1'b0, f_memread());
        cyc("lw_memread_rdy", 6'h23, 6'h00, 1'b1, 1'b0, f_memread());
        cyc("lw_memwb",       6'h23, 6'h00, 1'b1, 1'b0, f_memwb());
        exp_cnt = 8'd2;

        cyc("beq_fetch_wait", 6'h04, 6'h00, 1'b0, 1'b0, f_fetch(1'b0));
        cyc("beq_fetch",      6'h04, 6'h00, 1'b1, 1'b0, f_fetch(1'b1));
        cyc("beq_decode",     6'h04, 6'h00, 1'b1, 1'b0, f_decode(1'b0));
        cyc("beq_branch",     6'h04, 6'h00, 1'b1, 1'b0, f_branch());
        exp_cnt = 8'd3;

        cyc("jal_fetch",  6'h03, 6'h00, 1'b1, 1'b0, f_fetch(1'b1));
        cyc("jal_decode", 6'h03, 6'h00, 1'b1, 1'b0, f_decode(1'b0));
        cyc("jal_jump",   6'h03, 6'h00, 1'b1, 1'b0, f_jal());
        exp_cnt = 8'd4;

        cyc("ill_fetch",  6'h3f, 6'h00, 1'b1, 1'b0, f_fetch(1'b1));
        cyc("ill_decode", 6'h3f, 6'h00, 1'b1, 1'b0, f_decode(1'b1));

        cyc("ori_fetch",  6'h0d, 6'h00, 1'b1, 1'b0, f_fetch(1'b1));
        cyc("ori_decode", 6'h0d, 6'h00, 1'b1, 1'b0, f_decode(1'b0));
        cyc("ori_iexec",  6'h0d, 6'h00, 1'b1, 1'b0, f_iexec(1'b0, 3'b110));
        cyc("ori_iwb",    6'h0d, 6'h00, 1'b1, 1'b0, f_iwb());
        exp_cnt = 8'd5;

        cyc("sll_fetch",  6'h00, 6'h00, 1'b1, 1'b0, f_fetch(1'b1));
        cyc("sll_decode", 6'h00, 6'h00, 1'b1, 1'b0, f_decode(1'b0));
        cyc("sll_rexec",  6'h00, 6'h00, 1'b1, 1'b0, f_rexec(2'b10));
        cyc("sll_rwb",    6'h00, 6'h00, 1'b1, 1'b0, f_rwb());
        exp_cnt = 8'd6;

        cyc("sw_fetch",   6'h2b, 6'h00, 1'b1, 1'b0, f_fetch(1'b1));
        cyc("sw_decode",  6'h2b, 6'h00, 1'b1, 1'b0, f_decode(1'b0));
        cyc("sw_memaddr", 6'h2b, 6'h00, 1'b1, 1'b0, f_memaddr());
        for (int i = 0; i < 4; i++)
            cyc("sw_memwrite_wait", 6'h2b, 6'h00, 1'b0, 1'b0, f_memwrite());
        exp_fault = 1'b1;

        cyc("add_fetch_after_timeout", 6'h00, 6'h20, 1'b1, 1'b0, f_fetch(1'b1));
        cyc("add_decode", 6'h00, 6'h20, 1'b1, 1'b0, f_decode(1'b0));
        cyc("add_rexec",  6'h00, 6'h20, 1'b1, 1'b0, f_rexec(2'b01));
        e = f_rwb(); e.rw = 1'b0;
        cyc("add_rwb_in_reset", 6'h00, 6'h20, 1'b1, 1'b1, e);
        exp_cnt = 8'd0; exp_fault = 1'b0;
        cyc("fetch_after_reset", 6'h00, 6'h20, 1'b1, 1'b0, f_fetch(1'b1));

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences a multi-cycle MIPS datapath: fetch, decode, execute, memory and writeback, one step per clock.
- The datapath shares one memory for instructions and data, holds IR/A/B/ALUOut registers, and the ALU is driven through ALUOp.
- Adds a memory-ready handshake with timeout, an illegal-opcode flag and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 255, max consecutive wait cycles with mem_ready=0 before abort; 0 disables the timeout.
- CNT_W, 32, width of instr_count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- OpCode  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  0=PC address, 1=ALUOut address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load instruction register
- RegWrite  out  1  register-file write
- RegDst  out  2  00=rt, 01=rd, 10=$31
- MemtoReg  out  2  00=ALUOut, 01=MDR, 10=PC
- ALUSrcA  out  2  00=PC, 01=A, 10={27'b0,shamt}
- ALUSrcB  out  2  00=B, 01=4, 10=ext imm, 11=sext imm<<2
- ExtOp  out  1  1=sign-extend
- LuOp  out  1  1=imm<<16
- ALUOp  out  3  000 ADD, 001 SUB, 010 FUNCT, 011 AND, 100 SLT, 101 SLTU, 110 OR
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A
- state  out  4  current state, for debug
- illegal_insn  out  1  one-cycle pulse on unsupported opcode
- mem_fault  out  1  sticky; set on memory timeout
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset: state=FETCH. instr_count=0, mem_fault=0, timer=0.
- While reset=1, all strobes are forced 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_insn.
- Outputs: combinational from state (plus OpCode/Funct where noted). Any output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, JR=10, I_EXEC=11, I_WB=12.
- FETCH:
  - IorD=0, MemRead=1, ALUSrcA=00, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=00, ALUSrcB=11, ExtOp=1, ALUOp=ADD. Next state by OpCode:
  - 0x23 lw, 0x2b sw -> MEM_ADDR
  - 0x00 with Funct 0x08 jr or 0x09 jalr -> JR
  - 0x00 other -> R_EXEC
  - 0x04 beq -> BRANCH
  - 0x02 j, 0x03 jal -> JUMP
  - 0x08, 0x09, 0x0a, 0x0b, 0x0c, 0x0d, 0x0f -> I_EXEC
  - other -> illegal_insn=1 for this cycle, go to FETCH, not counted.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ExtOp=1, ALUOp=ADD. Next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: IorD=1, MemRead=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: RegDst=00, MemtoReg=01, RegWrite=1. Next FETCH.
- MEM_WRITE: IorD=1, MemWrite=1. Wait for mem_ready, then FETCH.
- R_EXEC: ALUSrcA=10 if Funct is 0x00, 0x02 or 0x03, else 01. ALUSrcB=00, ALUOp=FUNCT. Next R_WB.
- R_WB: RegDst=01, MemtoReg=00, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01. Next FETCH.
- JUMP: PCWrite=1, PCSource=10. For jal also RegWrite=1, RegDst=10, MemtoReg=10 (PC already holds PC+4). Next FETCH.
- JR: PCWrite=1, PCSource=11. For jalr also RegWrite=1, RegDst=01, MemtoReg=10. Next FETCH.
- I_EXEC: ALUSrcA=01, ALUSrcB=10.
  - ExtOp=1 except andi (0x0c), ori (0x0d) and sltiu (0x0b), which use ExtOp=0. LuOp=1 for lui.
  - ALUOp: ADD for addi/addiu/lui, AND for andi, OR for ori, SLT for slti, SLTU for sltiu.
  - Next I_WB.
- I_WB: RegDst=00, MemtoReg=00, RegWrite=1. Next FETCH.
- Latency in cycles (all wait states at zero wait): R/I-type 4, lw 5, sw 4, beq/j/jal/jr 3.
- instr_count: +1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, JR or I_WB. Wraps modulo 2^CNT_W.
- Timeout (wait states are FETCH, MEM_READ, MEM_WRITE):
  - Timer clears on entry to a wait state and when mem_ready=1; otherwise it increments.
  - When MEM_TIMEOUT>0 and the timer reaches MEM_TIMEOUT-1 with mem_ready=0: set mem_fault, next state FETCH, PC/IR/register file untouched, instruction not counted.
  - A FETCH timeout re-enters FETCH with the timer cleared.
- mem_ready=1 in a non-wait state is ignored.
- Reset asserted mid-instruction: state returns to FETCH next cycle; no strobe is issued during the reset cycle.

Decomposition:
- Package mc_pkg holds the state encoding, opcode/funct constants, ALUOp codes and the mux-select codes listed above.
- One sub-module, mc_mem_timer: wait-cycle counter and timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- addi (0x08) with mem_ready always 1 -> states 0,1,11,12,0. RegWrite=1 only in state 12 with RegDst=00; instr_count=1.
- lw with mem_ready low for 3 cycles in MEM_READ -> MemRead held 4 cycles, IorD=1. MEM_WB follows the ready cycle; total 8 cycles.
- beq then jal -> BRANCH asserts PCWriteCond=1, PCSource=01. JUMP asserts PCWrite, RegWrite, RegDst=10, MemtoReg=10. instr_count=2.
- OpCode 0x3f -> illegal_insn pulses in cycle 2, next state FETCH, instr_count unchanged.
- MEM_TIMEOUT=4, mem_ready=0 forever in MEM_WRITE -> after 4 cycles state=0, mem_fault=1 sticky, MemWrite drops, no count.
- reset pulsed during R_WB -> RegWrite=0 that cycle; state=0, instr_count=0, mem_fault=0 on the next cycle.
